// File: rtl/tl_xbar_nto1.sv
// rtl/tl_xbar_nto1.sv - N-client to 1-manager TileLink-UL crossbar with round-robin A arbitration and D routing.
// Optional per-client outstanding-request limit: define TLXBAR_MAXFLIGHT_EN.
module tl_xbar_nto1 #(
    parameter  int N_IN    = 2,
    parameter  int SRC_W   = 5,
    parameter  int ADDR_W  = 31,
    parameter  int DATA_W  = 64,
    parameter  int SIZE_W  = 3,
    parameter  int MAX_FLT = 4,
    localparam int IDX_W   = $clog2(N_IN),
    localparam int MASK_W  = DATA_W / 8,
    localparam int LGB     = $clog2(MASK_W),
    localparam int OSRC_W  = SRC_W + IDX_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_IN-1:0]          auto_in_a_valid,
    output logic [N_IN-1:0]          auto_in_a_ready,
    input  logic [N_IN*3-1:0]        auto_in_a_bits_opcode,
    input  logic [N_IN*3-1:0]        auto_in_a_bits_param,
    input  logic [N_IN*SIZE_W-1:0]   auto_in_a_bits_size,
    input  logic [N_IN*SRC_W-1:0]    auto_in_a_bits_source,
    input  logic [N_IN*ADDR_W-1:0]   auto_in_a_bits_address,
    input  logic [N_IN*MASK_W-1:0]   auto_in_a_bits_mask,
    input  logic [N_IN*DATA_W-1:0]   auto_in_a_bits_data,
    input  logic [N_IN-1:0]          auto_in_a_bits_corrupt,
    output logic [N_IN-1:0]          auto_in_d_valid,
    input  logic [N_IN-1:0]          auto_in_d_ready,
    output logic [N_IN*3-1:0]        auto_in_d_bits_opcode,
    output logic [N_IN*2-1:0]        auto_in_d_bits_param,
    output logic [N_IN*SIZE_W-1:0]   auto_in_d_bits_size,
    output logic [N_IN*SRC_W-1:0]    auto_in_d_bits_source,
    output logic [N_IN-1:0]          auto_in_d_bits_sink,
    output logic [N_IN-1:0]          auto_in_d_bits_denied,
    output logic [N_IN*DATA_W-1:0]   auto_in_d_bits_data,
    output logic [N_IN-1:0]          auto_in_d_bits_corrupt,
    output logic                     auto_out_a_valid,
    input  logic                     auto_out_a_ready,
    output logic [2:0]               auto_out_a_bits_opcode,
    output logic [2:0]               auto_out_a_bits_param,
    output logic [SIZE_W-1:0]        auto_out_a_bits_size,
    output logic [OSRC_W-1:0]        auto_out_a_bits_source,
    output logic [ADDR_W-1:0]        auto_out_a_bits_address,
    output logic [MASK_W-1:0]        auto_out_a_bits_mask,
    output logic [DATA_W-1:0]        auto_out_a_bits_data,
    output logic                     auto_out_a_bits_corrupt,
    input  logic                     auto_out_d_valid,
    output logic                     auto_out_d_ready,
    input  logic [2:0]               auto_out_d_bits_opcode,
    input  logic [1:0]               auto_out_d_bits_param,
    input  logic [SIZE_W-1:0]        auto_out_d_bits_size,
    input  logic [OSRC_W-1:0]        auto_out_d_bits_source,
    input  logic                     auto_out_d_bits_sink,
    input  logic                     auto_out_d_bits_denied,
    input  logic [DATA_W-1:0]        auto_out_d_bits_data,
    input  logic                     auto_out_d_bits_corrupt
);

    localparam logic [SIZE_W-1:0] LGB_S = SIZE_W'(LGB);
    localparam int                IDX_N = 1 << IDX_W;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic             lock;
    logic [7:0]       beats_left;

    logic [N_IN-1:0]  eligible;
    logic [IDX_W-1:0] scan_win;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             grant_ok;
    logic             a_fire;
    logic             a_first;
    logic             a_burst;
    logic [2:0]       win_opcode;
    logic [SIZE_W-1:0] win_size;

    logic [IDX_W-1:0] tgt;
    logic [IDX_N-1:0] d_ready_ext;
    logic [IDX_N-1:0] legal_ext;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) == N_IN - 1) return '0;
        return idx + 1'b1;
    endfunction

    // Beats remaining after the first one for a burst of 2**sz bytes.
    function automatic logic [7:0] extra_beats(input logic [SIZE_W-1:0] sz);
        logic [8:0] one;
        logic [8:0] m;
        one = 9'd1 << (sz - LGB_S);
        m   = one - 9'd1;
        return m[7:0];
    endfunction

    always_comb begin
        int j;
        logic [IDX_W-1:0] cand;
        found    = 1'b0;
        scan_win = rr_ptr;
        j        = 0;
        cand     = '0;
        for (int k = 0; k < N_IN; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_IN) j = j - N_IN;
            cand = IDX_W'(j);
            if (!found && eligible[cand]) begin
                found    = 1'b1;
                scan_win = cand;
            end
        end
    end

    assign winner     = lock ? owner : scan_win;
    assign grant_ok   = lock | found;
    assign win_opcode = auto_in_a_bits_opcode[winner*3 +: 3];
    assign win_size   = auto_in_a_bits_size[winner*SIZE_W +: SIZE_W];

    assign auto_out_a_valid        = !reset && grant_ok && auto_in_a_valid[winner];
    assign auto_out_a_bits_opcode  = win_opcode;
    assign auto_out_a_bits_param   = auto_in_a_bits_param[winner*3 +: 3];
    assign auto_out_a_bits_size    = win_size;
    assign auto_out_a_bits_source  = {winner, auto_in_a_bits_source[winner*SRC_W +: SRC_W]};
    assign auto_out_a_bits_address = auto_in_a_bits_address[winner*ADDR_W +: ADDR_W];
    assign auto_out_a_bits_mask    = auto_in_a_bits_mask[winner*MASK_W +: MASK_W];
    assign auto_out_a_bits_data    = auto_in_a_bits_data[winner*DATA_W +: DATA_W];
    assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt[winner];

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_ready
            assign auto_in_a_ready[gi] = !reset && grant_ok && auto_out_a_ready && (winner == IDX_W'(gi));
        end
    endgenerate

    assign a_fire  = auto_out_a_valid && auto_out_a_ready;
    assign a_first = !(lock && (beats_left != 8'd0));
    assign a_burst = !win_opcode[2] && (win_size > LGB_S);

    // A lock taken on a stalled first beat keeps beats_left at 0, so its fire still counts as a first beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            owner      <= '0;
            lock       <= 1'b0;
            beats_left <= 8'd0;
        end else if (a_fire) begin
            if (a_first) begin
                if (a_burst) begin
                    lock       <= 1'b1;
                    owner      <= winner;
                    beats_left <= extra_beats(win_size);
                end else begin
                    lock   <= 1'b0;
                    rr_ptr <= next_idx(winner);
                end
            end else begin
                beats_left <= beats_left - 8'd1;
                if (beats_left == 8'd1) begin
                    lock   <= 1'b0;
                    rr_ptr <= next_idx(owner);
                end
            end
        end else if (auto_out_a_valid && !lock) begin
            lock  <= 1'b1;
            owner <= winner;
        end
    end

    assign tgt = auto_out_d_bits_source[OSRC_W-1:SRC_W];

    always_comb begin
        d_ready_ext              = '1;
        d_ready_ext[N_IN-1:0]    = auto_in_d_ready;
        legal_ext                = '0;
        legal_ext[N_IN-1:0]      = '1;
    end

    // Beats aimed at a nonexistent client are swallowed so the manager never deadlocks.
    assign auto_out_d_ready = d_ready_ext[tgt];

    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_dvalid
            assign auto_in_d_valid[gi] = auto_out_d_valid && (tgt == IDX_W'(gi));
        end
    endgenerate

    assign auto_in_d_bits_opcode  = {N_IN{auto_out_d_bits_opcode}};
    assign auto_in_d_bits_param   = {N_IN{auto_out_d_bits_param}};
    assign auto_in_d_bits_size    = {N_IN{auto_out_d_bits_size}};
    assign auto_in_d_bits_source  = {N_IN{auto_out_d_bits_source[SRC_W-1:0]}};
    assign auto_in_d_bits_sink    = {N_IN{auto_out_d_bits_sink}};
    assign auto_in_d_bits_denied  = {N_IN{auto_out_d_bits_denied}};
    assign auto_in_d_bits_data    = {N_IN{auto_out_d_bits_data}};
    assign auto_in_d_bits_corrupt = {N_IN{auto_out_d_bits_corrupt}};

    d_target_legal: assert property (@(posedge clock) disable iff (reset)
        auto_out_d_valid |-> legal_ext[tgt]);

`ifdef TLXBAR_MAXFLIGHT_EN
    localparam int FLT_W = $clog2(MAX_FLT + 1);

    logic [7:0] d_left;
    logic       d_fire;
    logic       d_multi;
    logic       d_last;

    assign d_fire  = auto_out_d_valid && auto_out_d_ready;
    assign d_multi = (auto_out_d_bits_opcode == 3'd1) && (auto_out_d_bits_size > LGB_S);
    assign d_last  = (d_left == 8'd0) ? !d_multi : (d_left == 8'd1);

    // D beats of one message are never interleaved with another, so one shared beat counter suffices.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_left <= 8'd0;
        end else if (d_fire) begin
            if (d_left == 8'd0) d_left <= d_multi ? extra_beats(auto_out_d_bits_size) : 8'd0;
            else                d_left <= d_left - 8'd1;
        end
    end

    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_flt
            logic [FLT_W-1:0] cnt;
            logic             inc;
            logic             dec;
            assign inc = a_fire && a_first && (winner == IDX_W'(gi));
            assign dec = d_fire && d_last && (tgt == IDX_W'(gi));
            always_ff @(posedge clock or posedge reset) begin
                if (reset)           cnt <= '0;
                else if (inc && !dec) cnt <= cnt + 1'b1;
                else if (dec && !inc) cnt <= cnt - 1'b1;
            end
            assign eligible[gi] = auto_in_a_valid[gi] && (cnt != FLT_W'(MAX_FLT));
        end
    endgenerate
`else
    localparam int unused_max_flt = MAX_FLT;
    assign eligible = auto_in_a_valid;
`endif

endmodule

// File: tb/tb_tl_xbar_nto1.sv
// tb/tb_tl_xbar_nto1.sv - directed self-checking bench for tl_xbar_nto1 (N_IN=2).
module tb_tl_xbar_nto1;

    localparam int N = 2, SW = 5, AW = 31, DW = 64, ZW = 3, MW = 8, OSW = 6;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    in_a_valid;
    logic [N-1:0]    in_a_ready;
    logic [N*3-1:0]  in_a_opcode, in_a_param;
    logic [N*ZW-1:0] in_a_size;
    logic [N*SW-1:0] in_a_source;
    logic [N*AW-1:0] in_a_address;
    logic [N*MW-1:0] in_a_mask;
    logic [N*DW-1:0] in_a_data;
    logic [N-1:0]    in_a_corrupt;
    logic [N-1:0]    in_d_valid, in_d_ready;
    logic [N*3-1:0]  in_d_opcode;
    logic [N*2-1:0]  in_d_param;
    logic [N*ZW-1:0] in_d_size;
    logic [N*SW-1:0] in_d_source;
    logic [N-1:0]    in_d_sink, in_d_denied, in_d_corrupt;
    logic [N*DW-1:0] in_d_data;
    logic            out_a_valid, out_a_ready, out_a_corrupt;
    logic [2:0]      out_a_opcode, out_a_param;
    logic [ZW-1:0]   out_a_size;
    logic [OSW-1:0]  out_a_source;
    logic [AW-1:0]   out_a_address;
    logic [MW-1:0]   out_a_mask;
    logic [DW-1:0]   out_a_data;
    logic            out_d_valid, out_d_ready, out_d_sink, out_d_denied, out_d_corrupt;
    logic [2:0]      out_d_opcode;
    logic [1:0]      out_d_param;
    logic [ZW-1:0]   out_d_size;
    logic [OSW-1:0]  out_d_source;
    logic [DW-1:0]   out_d_data;

    int tests = 0;
    int failed = 0;

    tl_xbar_nto1 #(.N_IN(N), .SRC_W(SW), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(ZW), .MAX_FLT(2)) dut (
        .clock(clock), .reset(reset),
        .auto_in_a_valid(in_a_valid), .auto_in_a_ready(in_a_ready),
        .auto_in_a_bits_opcode(in_a_opcode), .auto_in_a_bits_param(in_a_param),
        .auto_in_a_bits_size(in_a_size), .auto_in_a_bits_source(in_a_source),
        .auto_in_a_bits_address(in_a_address), .auto_in_a_bits_mask(in_a_mask),
        .auto_in_a_bits_data(in_a_data), .auto_in_a_bits_corrupt(in_a_corrupt),
        .auto_in_d_valid(in_d_valid), .auto_in_d_ready(in_d_ready),
        .auto_in_d_bits_opcode(in_d_opcode), .auto_in_d_bits_param(in_d_param),
        .auto_in_d_bits_size(in_d_size), .auto_in_d_bits_source(in_d_source),
        .auto_in_d_bits_sink(in_d_sink), .auto_in_d_bits_denied(in_d_denied),
        .auto_in_d_bits_data(in_d_data), .auto_in_d_bits_corrupt(in_d_corrupt),
        .auto_out_a_valid(out_a_valid), .auto_out_a_ready(out_a_ready),
        .auto_out_a_bits_opcode(out_a_opcode), .auto_out_a_bits_param(out_a_param),
        .auto_out_a_bits_size(out_a_size), .auto_out_a_bits_source(out_a_source),
        .auto_out_a_bits_address(out_a_address), .auto_out_a_bits_mask(out_a_mask),
        .auto_out_a_bits_data(out_a_data), .auto_out_a_bits_corrupt(out_a_corrupt),
        .auto_out_d_valid(out_d_valid), .auto_out_d_ready(out_d_ready),
        .auto_out_d_bits_opcode(out_d_opcode), .auto_out_d_bits_param(out_d_param),
        .auto_out_d_bits_size(out_d_size), .auto_out_d_bits_source(out_d_source),
        .auto_out_d_bits_sink(out_d_sink), .auto_out_d_bits_denied(out_d_denied),
        .auto_out_d_bits_data(out_d_data), .auto_out_d_bits_corrupt(out_d_corrupt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_a(input int i, input logic v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [4:0] src, input logic [30:0] addr, input logic [63:0] dat);
        in_a_valid[i]          = v;
        in_a_opcode[i*3 +: 3]  = op;
        in_a_param[i*3 +: 3]   = 3'd0;
        in_a_size[i*ZW +: ZW]  = sz;
        in_a_source[i*SW +: SW] = src;
        in_a_address[i*AW +: AW] = addr;
        in_a_mask[i*MW +: MW]  = 8'hFF;
        in_a_data[i*DW +: DW]  = dat;
        in_a_corrupt[i]        = 1'b0;
    endtask

    task automatic clear_inputs();
        in_a_valid = '0; in_a_opcode = '0; in_a_param = '0; in_a_size = '0;
        in_a_source = '0; in_a_address = '0; in_a_mask = '0; in_a_data = '0; in_a_corrupt = '0;
        in_d_ready = '0; out_a_ready = 1'b0;
        out_d_valid = 1'b0; out_d_opcode = '0; out_d_param = '0; out_d_size = '0; out_d_source = '0;
        out_d_sink = 1'b0; out_d_denied = 1'b0; out_d_data = '0; out_d_corrupt = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        set_a(0, 1'b1, 3'd4, 3'd3, 5'd1, 31'h10, 64'h0);
        set_a(1, 1'b1, 3'd4, 3'd3, 5'd2, 31'h20, 64'h0);
        out_a_ready = 1'b1;
        out_d_valid = 1'b1; out_d_source = 6'h21; in_d_ready = 2'b10;
        @(negedge clock);
        tests++; if (out_a_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b want 0", out_a_valid); end
        tests++; if (in_a_ready !== 2'b00) begin failed++; $display("FAIL reset_in_ready got %b want 00", in_a_ready); end
        tests++; if (in_d_valid !== 2'b10 || out_d_ready !== 1'b1) begin failed++;
            $display("FAIL reset_d_path got dvalid=%b dready=%b want 10/1", in_d_valid, out_d_ready); end
        do_reset();
    endtask

    task automatic test_collision();
        do_reset();
        out_a_ready = 1'b1;
        set_a(0, 1'b1, 3'd4, 3'd3, 5'd5, 31'h100, 64'h0);
        set_a(1, 1'b1, 3'd4, 3'd3, 5'd5, 31'h200, 64'h0);
        @(negedge clock);
        tests++; if (out_a_valid !== 1'b1 || out_a_source !== 6'h05 || out_a_address !== 31'h100 || in_a_ready !== 2'b01) begin
            failed++; $display("FAIL collision_c0 got v=%b src=%h addr=%h rdy=%b want 1/05/100/01",
                out_a_valid, out_a_source, out_a_address, in_a_ready); end
        tick();
        in_a_valid[0] = 1'b0;
        @(negedge clock);
        tests++; if (out_a_valid !== 1'b1 || out_a_source !== 6'h25 || out_a_address !== 31'h200 || in_a_ready !== 2'b10) begin
            failed++; $display("FAIL collision_c1 got v=%b src=%h addr=%h rdy=%b want 1/25/200/10",
                out_a_valid, out_a_source, out_a_address, in_a_ready); end
        tick();
        in_a_valid[1] = 1'b0;
        @(negedge clock);
        tests++; if (out_a_valid !== 1'b0) begin failed++; $display("FAIL collision_idle got %b want 0", out_a_valid); end
        tick();
    endtask

    task automatic test_burst();
        do_reset();
        out_a_ready = 1'b1;
        set_a(0, 1'b1, 3'd4, 3'd3, 5'd5, 31'h300, 64'h0);
        tick();
        set_a(0, 1'b1, 3'd4, 3'd3, 5'd5, 31'h310, 64'h0);
        set_a(1, 1'b1, 3'd0, 3'd5, 5'd2, 31'h400, 64'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            tests++; if (out_a_source !== 6'h22 || out_a_data !== 64'(b) || in_a_ready !== 2'b10) begin
                failed++; $display("FAIL burst_beat%0d got src=%h data=%h rdy=%b want 22/%0d/10",
                    b, out_a_source, out_a_data, in_a_ready, b); end
            tick();
            if (b < 3) in_a_data[DW +: DW] = 64'(b + 1);
            else set_a(1, 1'b1, 3'd4, 3'd3, 5'd3, 31'h500, 64'h0);
        end
        @(negedge clock);
        tests++; if (out_a_source !== 6'h05 || out_a_address !== 31'h310 || in_a_ready !== 2'b01) begin
            failed++; $display("FAIL burst_after_c0 got src=%h addr=%h rdy=%b want 05/310/01",
                out_a_source, out_a_address, in_a_ready); end
        tick();
        in_a_valid[0] = 1'b0;
        @(negedge clock);
        tests++; if (out_a_source !== 6'h23 || out_a_address !== 31'h500 || in_a_ready !== 2'b10) begin
            failed++; $display("FAIL burst_after_c1 got src=%h addr=%h rdy=%b want 23/500/10",
                out_a_source, out_a_address, in_a_ready); end
        tick();
        in_a_valid[1] = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_a_ready = 1'b1;
        set_a(0, 1'b1, 3'd4, 3'd3, 5'd5, 31'h600, 64'h0);
        tick();
        out_a_ready = 1'b0;
        set_a(0, 1'b1, 3'd4, 3'd3, 5'd7, 31'h610, 64'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            tests++; if (out_a_valid !== 1'b1 || out_a_source !== 6'h07 || out_a_address !== 31'h610 || in_a_ready !== 2'b00) begin
                failed++; $display("FAIL bp_hold%0d got v=%b src=%h addr=%h rdy=%b want 1/07/610/00",
                    c, out_a_valid, out_a_source, out_a_address, in_a_ready); end
            tick();
            if (c == 0) set_a(1, 1'b1, 3'd4, 3'd3, 5'd9, 31'h700, 64'h0);
        end
        out_a_ready = 1'b1;
        @(negedge clock);
        tests++; if (out_a_source !== 6'h07 || in_a_ready !== 2'b01) begin
            failed++; $display("FAIL bp_release got src=%h rdy=%b want 07/01", out_a_source, in_a_ready); end
        tick();
        in_a_valid[0] = 1'b0;
        @(negedge clock);
        tests++; if (out_a_source !== 6'h29 || out_a_address !== 31'h700 || in_a_ready !== 2'b10) begin
            failed++; $display("FAIL bp_next got src=%h addr=%h rdy=%b want 29/700/10",
                out_a_source, out_a_address, in_a_ready); end
        tick();
        in_a_valid[1] = 1'b0;
    endtask

    task automatic test_d_routing();
        do_reset();
        out_d_valid = 1'b1; out_d_source = 6'h23; out_d_opcode = 3'd1; out_d_size = 3'd3;
        out_d_data = 64'hDEAD_BEEF_0123_4567; in_d_ready = 2'b01;
        @(negedge clock);
        tests++; if (in_d_valid !== 2'b10 || in_d_source[SW +: SW] !== 5'h03 || out_d_ready !== 1'b0) begin
            failed++; $display("FAIL d_route1 got dvalid=%b src=%h dready=%b want 10/03/0",
                in_d_valid, in_d_source[SW +: SW], out_d_ready); end
        tests++; if (in_d_data[DW +: DW] !== 64'hDEAD_BEEF_0123_4567 || in_d_opcode[5:3] !== 3'd1) begin
            failed++; $display("FAIL d_payload got data=%h op=%0d want deadbeef01234567/1",
                in_d_data[DW +: DW], in_d_opcode[5:3]); end
        in_d_ready = 2'b10;
        #1;
        tests++; if (out_d_ready !== 1'b1) begin failed++; $display("FAIL d_ready1 got %b want 1", out_d_ready); end
        out_d_source = 6'h04; in_d_ready = 2'b01;
        #1;
        tests++; if (in_d_valid !== 2'b01 || in_d_source[SW-1:0] !== 5'h04 || out_d_ready !== 1'b1) begin
            failed++; $display("FAIL d_route0 got dvalid=%b src=%h dready=%b want 01/04/1",
                in_d_valid, in_d_source[SW-1:0], out_d_ready); end
        in_d_ready = 2'b10;
        #1;
        tests++; if (out_d_ready !== 1'b0) begin failed++; $display("FAIL d_ready0 got %b want 0", out_d_ready); end
        out_d_valid = 1'b0; in_d_ready = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        out_a_ready = 1'b1;
        set_a(0, 1'b1, 3'd4, 3'd3, 5'd5, 31'h780, 64'h0);
        tick();
        in_a_valid[0] = 1'b0;
        set_a(1, 1'b1, 3'd0, 3'd5, 5'd1, 31'h800, 64'd0);
        tick();
        in_a_data[DW +: DW] = 64'd1;
        @(negedge clock);
        tests++; if (out_a_source !== 6'h21 || in_a_ready !== 2'b10) begin
            failed++; $display("FAIL rmb_beat2 got src=%h rdy=%b want 21/10", out_a_source, in_a_ready); end
        tick();
        reset = 1'b1;
        set_a(0, 1'b1, 3'd4, 3'd3, 5'd4, 31'h900, 64'h0);
        #1;
        tests++; if (out_a_valid !== 1'b0 || in_a_ready !== 2'b00) begin
            failed++; $display("FAIL rmb_in_reset got v=%b rdy=%b want 0/00", out_a_valid, in_a_ready); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        tests++; if (out_a_valid !== 1'b1 || out_a_source !== 6'h04 || in_a_ready !== 2'b01) begin
            failed++; $display("FAIL rmb_after got v=%b src=%h rdy=%b want 1/04/01",
                out_a_valid, out_a_source, in_a_ready); end
        tick();
        in_a_valid = 2'b00;
        @(negedge clock);
        tests++; if (out_a_valid !== 1'b0) begin failed++; $display("FAIL rmb_idle got %b want 0", out_a_valid); end
        tick();
    endtask

`ifdef TLXBAR_MAXFLIGHT_EN
    task automatic test_maxflight();
        do_reset();
        out_a_ready = 1'b1;
        set_a(0, 1'b1, 3'd4, 3'd3, 5'd0, 31'hA00, 64'h0);
        for (int g = 0; g < 2; g++) begin
            @(negedge clock);
            tests++; if (out_a_valid !== 1'b1 || in_a_ready !== 2'b01) begin
                failed++; $display("FAIL mf_get%0d got v=%b rdy=%b want 1/01", g, out_a_valid, in_a_ready); end
            tick();
        end
        @(negedge clock);
        tests++; if (out_a_valid !== 1'b0 || in_a_ready !== 2'b00) begin
            failed++; $display("FAIL mf_stall got v=%b rdy=%b want 0/00", out_a_valid, in_a_ready); end
        tick();
        out_d_valid = 1'b1; out_d_opcode = 3'd1; out_d_size = 3'd3; out_d_source = 6'h00; in_d_ready = 2'b01;
        @(negedge clock);
        tests++; if (out_a_valid !== 1'b0 || in_d_valid !== 2'b01) begin
            failed++; $display("FAIL mf_dcycle got v=%b dvalid=%b want 0/01", out_a_valid, in_d_valid); end
        tick();
        out_d_valid = 1'b0; in_d_ready = 2'b00;
        @(negedge clock);
        tests++; if (out_a_valid !== 1'b1 || in_a_ready !== 2'b01) begin
            failed++; $display("FAIL mf_resume got v=%b rdy=%b want 1/01", out_a_valid, in_a_ready); end
        tick();
        in_a_valid[0] = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_collision();
        test_burst();
        test_backpressure();
        test_d_routing();
        test_reset_mid_burst();
`ifdef TLXBAR_MAXFLIGHT_EN
        test_maxflight();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
